// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller, immediate generator and ALU:
// FSM states, opcodes, imm_sel / alu_op / wb_sel encodings and the latched decode fields.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_NONE  = 3'b000;
    localparam logic [2:0] IMM_I     = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_SHAMT = 3'b100;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       funct7_5;
    } dec_reg_t;

    // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
    function automatic alu_op_e funct3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory-side bus of the controller: instruction fetch handshake and data access strobes.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_ready;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_size;

    modport master (
        input  instr, imem_ready, dmem_ready,
        output imem_req, mem_re, mem_we, mem_size
    );
    modport slave (
        output instr, imem_ready, dmem_ready,
        input  imem_req, mem_re, mem_we, mem_size
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of the latched opcode/funct3/funct7[5] into immediate, ALU and writeback controls.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  dec_reg_t   dec,
    output logic [2:0] imm_sel,
    output alu_op_e    alu_op,
    output logic       alu_src_imm,
    output logic       alu_src_pc,
    output logic [1:0] wb_sel,
    output logic       is_load,
    output logic       is_store,
    output logic       legal
);
    always_comb begin
        imm_sel     = IMM_NONE;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        wb_sel      = WB_ALU;
        is_load     = 1'b0;
        is_store    = 1'b0;
        legal       = 1'b1;
        case (dec.opcode)
            OPC_OP: begin
                alu_op = funct3_to_alu(dec.funct3, dec.funct7_5);
            end
            OPC_OP_IMM: begin
                // funct7[5] is immediate data for ADDI, only SRAI treats it as an opcode bit
                imm_sel     = (dec.funct3 == 3'b001 || dec.funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
                alu_op      = funct3_to_alu(dec.funct3, (dec.funct3 == 3'b101) && dec.funct7_5);
                alu_src_imm = 1'b1;
            end
            OPC_LOAD: begin
                imm_sel     = IMM_I;
                alu_src_imm = 1'b1;
                wb_sel      = WB_MEM;
                is_load     = 1'b1;
            end
            OPC_STORE: begin
                imm_sel     = IMM_S;
                alu_src_imm = 1'b1;
                is_store    = 1'b1;
            end
            OPC_LUI: begin
                imm_sel     = IMM_U;
                alu_op      = ALU_PASSB;
                alu_src_imm = 1'b1;
                wb_sel      = WB_IMM;
            end
            OPC_AUIPC: begin
                imm_sel     = IMM_U;
                alu_src_imm = 1'b1;
                alu_src_pc  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) driving all datapath enables.
// Define MULTICYCLE_CTRL_PERF_EN to build the cycle_o / instret_o performance counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus,
    output logic                ir_we,
    output logic                pc_we,
    output logic [2:0]          imm_sel,
    output logic                alu_src_imm,
    output logic                alu_src_pc,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic                illegal,
    output logic [2:0]          state_o,
    output logic [31:0]         instret_o,
    output logic [31:0]         cycle_o
);
    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e               state_reg, state_next;
    dec_reg_t             dec_reg, dec_next;
    logic [TMO_W-1:0]     tmo_cnt_reg;
    logic                 imem_req_reg, mem_re_reg, mem_we_reg, reg_we_reg, illegal_reg;
    logic                 alu_src_imm_reg, alu_src_pc_reg;
    logic [2:0]           imm_sel_reg, mem_size_reg;
    logic [1:0]           wb_sel_reg;
    logic [ALU_OP_W-1:0]  alu_op_reg;

    logic [2:0] d_imm_sel;
    alu_op_e    d_alu_op;
    logic       d_src_imm, d_src_pc, d_is_load, d_is_store, d_legal;
    logic [1:0] d_wb_sel;
    logic       fetch_accept;

    assign fetch_accept = (state_reg == S_FETCH) && bus.imem_ready;

    // Decoder looks at the value the decode register will hold, so registered outputs line up with the state
    always_comb begin
        dec_next = dec_reg;
        if (fetch_accept)
            dec_next = '{opcode: bus.instr[6:0], funct3: bus.instr[14:12], funct7_5: bus.instr[30]};
    end

    ctrl_decode u_decode (
        .dec         (dec_next),
        .imm_sel     (d_imm_sel),
        .alu_op      (d_alu_op),
        .alu_src_imm (d_src_imm),
        .alu_src_pc  (d_src_pc),
        .wb_sel      (d_wb_sel),
        .is_load     (d_is_load),
        .is_store    (d_is_store),
        .legal       (d_legal)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (bus.imem_ready) state_next = S_DECODE;
            S_DECODE: state_next = d_legal ? S_EXEC : S_HALT;
            S_EXEC:   state_next = (d_is_load || d_is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.dmem_ready)
                    state_next = d_is_load ? S_WB : S_FETCH;
                else if (MEM_TIMEOUT > 0 && tmo_cnt_reg == TMO_LAST)
                    state_next = S_HALT;
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    // Outputs are registered from the next state; ALU controls are held through MEM/WB so an
    // unregistered ALU result remains valid for address and writeback
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_FETCH;
            dec_reg         <= '0;
            tmo_cnt_reg     <= '0;
            imem_req_reg    <= 1'b1;
            imm_sel_reg     <= IMM_NONE;
            alu_op_reg      <= '0;
            alu_src_imm_reg <= 1'b0;
            alu_src_pc_reg  <= 1'b0;
            mem_re_reg      <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_size_reg    <= '0;
            reg_we_reg      <= 1'b0;
            wb_sel_reg      <= WB_ALU;
            illegal_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dec_reg         <= dec_next;
            tmo_cnt_reg     <= (state_reg == S_MEM && state_next == S_MEM) ? tmo_cnt_reg + 1'b1 : '0;
            imem_req_reg    <= (state_next == S_FETCH);
            imm_sel_reg     <= (state_next inside {S_DECODE, S_EXEC, S_MEM, S_WB}) ? d_imm_sel : IMM_NONE;
            alu_op_reg      <= (state_next inside {S_EXEC, S_MEM, S_WB}) ? ALU_OP_W'(d_alu_op) : '0;
            alu_src_imm_reg <= (state_next inside {S_EXEC, S_MEM, S_WB}) && d_src_imm;
            alu_src_pc_reg  <= (state_next inside {S_EXEC, S_MEM, S_WB}) && d_src_pc;
            mem_re_reg      <= (state_next == S_MEM) && d_is_load;
            mem_we_reg      <= (state_next == S_MEM) && d_is_store;
            mem_size_reg    <= (state_next == S_MEM) ? dec_next.funct3 : 3'b000;
            reg_we_reg      <= (state_next == S_WB);
            wb_sel_reg      <= (state_next == S_WB) ? d_wb_sel : WB_ALU;
            illegal_reg     <= (state_next == S_HALT);
        end
    end

    assign ir_we        = rst && fetch_accept;
    assign pc_we        = rst && fetch_accept;
    assign bus.imem_req = imem_req_reg;
    assign bus.mem_re   = mem_re_reg;
    assign bus.mem_we   = mem_we_reg;
    assign bus.mem_size = mem_size_reg;
    assign imm_sel      = imm_sel_reg;
    assign alu_op       = alu_op_reg;
    assign alu_src_imm  = alu_src_imm_reg;
    assign alu_src_pc   = alu_src_pc_reg;
    assign reg_we       = reg_we_reg;
    assign wb_sel       = wb_sel_reg;
    assign illegal      = illegal_reg;
    assign state_o      = state_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_reg, instret_reg;
    logic        retire;

    // An instruction retires leaving WB, or when a store completes straight back to FETCH
    assign retire = (state_reg == S_WB) || (state_reg == S_MEM && d_is_store && bus.dmem_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_reg   <= '0;
            instret_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (retire)
                instret_reg <= instret_reg + 32'd1;
        end
    end

    assign cycle_o   = cycle_reg;
    assign instret_o = instret_reg;
`else
    assign cycle_o   = '0;
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of single instructions with ready tied high, then hand-written
// sequences for memory wait, reset abort, illegal opcode and MEM timeout (second instance, MEM_TIMEOUT=4).
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus_t ();
    assign bus_t.instr      = bus.instr;
    assign bus_t.imem_ready = bus.imem_ready;
    assign bus_t.dmem_ready = bus.dmem_ready;

    logic        ir_we, pc_we, alu_src_imm, alu_src_pc, reg_we, illegal;
    logic [2:0]  imm_sel, state_o;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [31:0] instret_o, cycle_o;

    logic        t_ir_we, t_pc_we, t_alu_src_imm, t_alu_src_pc, t_reg_we, t_illegal;
    logic [2:0]  t_imm_sel, t_state_o;
    logic [3:0]  t_alu_op;
    logic [1:0]  t_wb_sel;
    logic [31:0] t_instret_o, t_cycle_o;

    multicycle_ctrl #(.ALU_OP_W(4), .MEM_TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ir_we(ir_we), .pc_we(pc_we), .imm_sel(imm_sel), .alu_src_imm(alu_src_imm),
        .alu_src_pc(alu_src_pc), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
        .illegal(illegal), .state_o(state_o), .instret_o(instret_o), .cycle_o(cycle_o)
    );

    multicycle_ctrl #(.ALU_OP_W(4), .MEM_TIMEOUT(4)) dut_tmo (
        .clk(clk), .rst(rst), .bus(bus_t),
        .ir_we(t_ir_we), .pc_we(t_pc_we), .imm_sel(t_imm_sel), .alu_src_imm(t_alu_src_imm),
        .alu_src_pc(t_alu_src_pc), .alu_op(t_alu_op), .reg_we(t_reg_we), .wb_sel(t_wb_sel),
        .illegal(t_illegal), .state_o(t_state_o), .instret_o(t_instret_o), .cycle_o(t_cycle_o)
    );

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;
    localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  kind;
        logic [2:0]  imm;
        logic [3:0]  alu;
        logic        src_imm;
        logic        src_pc;
        logic [1:0]  wb;
        logic [2:0]  size;
    } vec_t;

    vec_t vecs [12];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        cyc = 0;
    endtask

    // FETCH cycle with imem_ready; returns one cycle later (DECODE)
    task automatic issue(input logic [31:0] w);
        bus.instr      = w;
        bus.imem_ready = 1'b1;
        #1;
        chk("fetch_state", 32'(state_o), 32'(ST_FETCH));
        chk("fetch_ir_we", 32'(ir_we), 32'd1);
        chk("fetch_pc_we", 32'(pc_we), 32'd1);
        step();
        bus.instr      = '0;
        bus.imem_ready = 1'b0;
    endtask

    task automatic chk_perf(input int n_ret);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("instret", instret_o, 32'(n_ret));
        chk("cycle", cycle_o, 32'(cyc));
`else
        chk("instret_off", instret_o, 32'd0 + 32'(n_ret) * 32'd0);
        chk("cycle_off", cycle_o, 32'd0);
`endif
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        bus.dmem_ready = 1'b1;
        issue(v.instr);
        #1;
        chk("dec_state", 32'(state_o), 32'(ST_DECODE));
        chk("dec_imm_sel", 32'(imm_sel), 32'(v.imm));
        step(); #1;
        chk("exec_state", 32'(state_o), 32'(ST_EXEC));
        chk("exec_imm_sel", 32'(imm_sel), 32'(v.imm));
        chk("exec_alu_op", 32'(alu_op), 32'(v.alu));
        chk("exec_src_imm", 32'(alu_src_imm), 32'(v.src_imm));
        chk("exec_src_pc", 32'(alu_src_pc), 32'(v.src_pc));
        chk("exec_reg_we", 32'(reg_we), 32'd0);
        step(); #1;
        if (v.kind != K_ALU) begin
            chk("mem_state", 32'(state_o), 32'(ST_MEM));
            chk("mem_re", 32'(bus.mem_re), 32'(v.kind == K_LOAD));
            chk("mem_we", 32'(bus.mem_we), 32'(v.kind == K_STORE));
            chk("mem_size", 32'(bus.mem_size), 32'(v.size));
            step(); #1;
        end
        if (v.kind != K_STORE) begin
            chk("wb_state", 32'(state_o), 32'(ST_WB));
            chk("wb_reg_we", 32'(reg_we), 32'd1);
            chk("wb_sel", 32'(wb_sel), 32'(v.wb));
            step(); #1;
        end
        chk("ret_state", 32'(state_o), 32'(ST_FETCH));
        chk("ret_reg_we", 32'(reg_we), 32'd0);
        $display("vec %0d instr=%08h kind=%0d applied, errors so far %0d", i, v.instr, v.kind, errors);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            instr         kind     imm   alu    si    sp    wb    size
        vecs[0]  = '{32'h00500093, K_ALU,   3'd1, 4'd0,  1'b1, 1'b0, 2'd0, 3'd0}; // addi x1,x0,5
        vecs[1]  = '{32'h40315093, K_ALU,   3'd4, 4'd7,  1'b1, 1'b0, 2'd0, 3'd0}; // srai
        vecs[2]  = '{32'h403100b3, K_ALU,   3'd0, 4'd1,  1'b0, 1'b0, 2'd0, 3'd0}; // sub
        vecs[3]  = '{32'h123450b7, K_ALU,   3'd3, 4'd10, 1'b1, 1'b0, 2'd2, 3'd0}; // lui
        vecs[4]  = '{32'h00001097, K_ALU,   3'd3, 4'd0,  1'b1, 1'b1, 2'd0, 3'd0}; // auipc
        vecs[5]  = '{32'h00209093, K_ALU,   3'd4, 4'd2,  1'b1, 1'b0, 2'd0, 3'd0}; // slli
        vecs[6]  = '{32'hc0000093, K_ALU,   3'd1, 4'd0,  1'b1, 1'b0, 2'd0, 3'd0}; // addi, imm bit30 set
        vecs[7]  = '{32'h00412083, K_LOAD,  3'd1, 4'd0,  1'b1, 1'b0, 2'd1, 3'd2}; // lw
        vecs[8]  = '{32'h00112223, K_STORE, 3'd2, 4'd0,  1'b1, 1'b0, 2'd0, 3'd2}; // sw
        vecs[9]  = '{32'h003130b3, K_ALU,   3'd0, 4'd4,  1'b0, 1'b0, 2'd0, 3'd0}; // sltu
        vecs[10] = '{32'h403150b3, K_ALU,   3'd0, 4'd7,  1'b0, 1'b0, 2'd0, 3'd0}; // sra
        vecs[11] = '{32'h00014083, K_LOAD,  3'd1, 4'd0,  1'b1, 1'b0, 2'd1, 3'd4}; // lbu

        bus.instr      = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        #2;
        do_reset();
        #1;
        chk("rst_state", 32'(state_o), 32'(ST_FETCH));
        chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
        chk("rst_ctrl", {ir_we, pc_we, imm_sel, alu_op, alu_src_imm, alu_src_pc, reg_we, wb_sel, illegal}, 32'd0);
        chk("rst_mem", {bus.mem_re, bus.mem_we, bus.mem_size}, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i);
        chk_perf(12);

        // sw with dmem_ready low for three MEM cycles
        bus.dmem_ready = 1'b0;
        issue(32'h00112223);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            bus.dmem_ready = (k == 3);
            #1;
            chk("sw_wait_state", 32'(state_o), 32'(ST_MEM));
            chk("sw_wait_mem_we", 32'(bus.mem_we), 32'd1);
            chk("sw_wait_size", 32'(bus.mem_size), 32'd2);
            chk("sw_wait_reg_we", 32'(reg_we), 32'd0);
        end
        step();
        bus.dmem_ready = 1'b0;
        #1;
        chk("sw_done_state", 32'(state_o), 32'(ST_FETCH));
        chk("sw_done_mem_we", 32'(bus.mem_we), 32'd0);
        $display("seq sw-wait done, errors so far %0d", errors);

        // lw with dmem_ready arriving in the second MEM cycle
        issue(32'h00412083);
        step();
        step(); #1;
        chk("lw_mem1_re", 32'(bus.mem_re), 32'd1);
        step();
        bus.dmem_ready = 1'b1;
        #1;
        chk("lw_mem2_state", 32'(state_o), 32'(ST_MEM));
        chk("lw_mem2_re", 32'(bus.mem_re), 32'd1);
        step();
        bus.dmem_ready = 1'b0;
        #1;
        chk("lw_wb_state", 32'(state_o), 32'(ST_WB));
        chk("lw_wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_wb_reg_we", 32'(reg_we), 32'd1);
        chk("lw_wb_mem_re", 32'(bus.mem_re), 32'd0);
        step(); #1;
        chk("lw_done_state", 32'(state_o), 32'(ST_FETCH));
        chk_perf(14);
        $display("seq lw-wait done, errors so far %0d", errors);

        // branch opcode is unsupported: HALT after DECODE, illegal sticky until reset
        issue(32'h00000063);
        #1;
        chk("br_dec_state", 32'(state_o), 32'(ST_DECODE));
        step(); #1;
        chk("br_halt_state", 32'(state_o), 32'(ST_HALT));
        chk("br_illegal", 32'(illegal), 32'd1);
        step(); step(); step(); #1;
        chk("br_halt_held", 32'(state_o), 32'(ST_HALT));
        chk("br_illegal_held", 32'(illegal), 32'd1);
        chk("br_halt_req", 32'(bus.imem_req), 32'd0);
        do_reset();
        #1;
        chk("br_rst_state", 32'(state_o), 32'(ST_FETCH));
        chk("br_rst_illegal", 32'(illegal), 32'd0);
        $display("seq illegal-halt done, errors so far %0d", errors);

        // reset in the middle of a pending load
        issue(32'h00412083);
        step();
        step(); #1;
        chk("abort_mem_re_pre", 32'(bus.mem_re), 32'd1);
        do_reset();
        #1;
        chk("abort_state", 32'(state_o), 32'(ST_FETCH));
        chk("abort_mem_re", 32'(bus.mem_re), 32'd0);
        chk("abort_imem_req", 32'(bus.imem_req), 32'd1);
        $display("seq reset-mid-mem done, errors so far %0d", errors);

        // dmem_ready stuck low: MEM_TIMEOUT=4 instance halts after 4 MEM cycles, default waits
        issue(32'h00112223);
        step();
        for (int k = 1; k <= 4; k++) begin
            step(); #1;
            chk("tmo_mem_state", 32'(t_state_o), 32'(ST_MEM));
            chk("tmo_mem_illegal", 32'(t_illegal), 32'd0);
        end
        step(); #1;
        chk("tmo_halt_state", 32'(t_state_o), 32'(ST_HALT));
        chk("tmo_halt_illegal", 32'(t_illegal), 32'd1);
        chk("nolimit_state", 32'(state_o), 32'(ST_MEM));
        chk("nolimit_mem_we", 32'(bus.mem_we), 32'd1);
        step(); step(); #1;
        chk("nolimit_state_late", 32'(state_o), 32'(ST_MEM));
        chk("nolimit_illegal", 32'(illegal), 32'd0);
        $display("seq mem-timeout done, errors so far %0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
